// File: rtl/power_switch_ctrl.sv
// power_switch_ctrl
// Sequences a daisy chain of power-switch segments on and off one segment
// at a time, with a programmable settle delay between consecutive toggles.
// The switch enables are always thermometer-coded from the segment index.
// sleep_ack only moves when a ramp completes.
module power_switch_ctrl #(
    parameter int unsigned N_SWITCH = 8,
    parameter int unsigned STEP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sleep_req,
    input  logic [STEP_W-1:0]   step_cycles,
    output logic [N_SWITCH-1:0] switch_en,
    output logic                sleep_ack,
    output logic                busy
);

    localparam int unsigned IDX_W = $clog2(N_SWITCH + 1);
    localparam logic [IDX_W-1:0] N_IDX = IDX_W'(N_SWITCH);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [STEP_W-1:0]     timer_q, timer_d;
    logic [N_SWITCH-1:0]   switch_en_q, switch_en_d;
    logic                  sleep_ack_q, sleep_ack_d;
    logic                  busy_q, busy_d;

    logic [STEP_W-1:0]     step_eff;
    logic [STEP_W-1:0]     reload;

    // Effective delay: a zero setting behaves as a one-cycle delay.
    always_comb begin
        step_eff = (step_cycles == '0) ? STEP_W'(1) : step_cycles;
        reload   = step_eff - STEP_W'(1);
    end

    // Next-state, index, timer and output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        sleep_ack_d = sleep_ack_q;
        busy_d      = busy_q;

        case (state_q)
            OFF: begin
                if (!sleep_req) begin
                    state_d = RAMP_UP;
                    idx_d   = IDX_W'(1);
                    timer_d = reload;
                    busy_d  = 1'b1;
                end
            end

            RAMP_UP: begin
                if (sleep_req) begin
                    // Reverse immediately without waiting for the timer.
                    state_d = RAMP_DOWN;
                    idx_d   = idx_q - IDX_W'(1);
                    timer_d = reload;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - STEP_W'(1);
                end else if (idx_q < N_IDX) begin
                    idx_d   = idx_q + IDX_W'(1);
                    timer_d = reload;
                end else begin
                    state_d     = ON;
                    sleep_ack_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end

            ON: begin
                if (sleep_req) begin
                    state_d = RAMP_DOWN;
                    idx_d   = N_IDX - IDX_W'(1);
                    timer_d = reload;
                    busy_d  = 1'b1;
                end
            end

            RAMP_DOWN: begin
                if (!sleep_req) begin
                    // Reverse immediately; idx is always below N_SWITCH here.
                    state_d = RAMP_UP;
                    idx_d   = idx_q + IDX_W'(1);
                    timer_d = reload;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - STEP_W'(1);
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - IDX_W'(1);
                    timer_d = reload;
                end else begin
                    state_d     = OFF;
                    sleep_ack_d = 1'b1;
                    busy_d      = 1'b0;
                end
            end

            default: begin
                state_d     = OFF;
                idx_d       = '0;
                timer_d     = '0;
                sleep_ack_d = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    // Switch enables follow the next index as a thermometer code.
    always_comb begin
        switch_en_d = '0;
        for (int unsigned i = 0; i < N_SWITCH; i++) begin
            switch_en_d[i] = (i < 32'(idx_d));
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= OFF;
            idx_q       <= '0;
            timer_q     <= '0;
            switch_en_q <= '0;
            sleep_ack_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            switch_en_q <= switch_en_d;
            sleep_ack_q <= sleep_ack_d;
            busy_q      <= busy_d;
        end
    end

    assign switch_en = switch_en_q;
    assign sleep_ack = sleep_ack_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_power_switch_ctrl.sv
// Testbench for power_switch_ctrl: directed scenarios with literal
// expectations plus randomized stimulus compared every cycle against a
// deadline-based behavioural model.
module tb_power_switch_ctrl;

    localparam int N      = 8;
    localparam int STEP_W = 8;

    logic              clk;
    logic              rst;
    logic              sleep_req;
    logic [STEP_W-1:0] step_cycles;
    logic [N-1:0]      switch_en;
    logic              sleep_ack;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    power_switch_ctrl #(.N_SWITCH(N), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sleep_req  (sleep_req),
        .step_cycles(step_cycles),
        .switch_en  (switch_en),
        .sleep_ack  (sleep_ack),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: number of segments on, ramp direction and absolute edge of the next action.
    int     m_lvl  = 0;
    int     m_dir  = 0;
    longint m_cyc  = 0;
    longint m_next = 0;
    bit     m_ack  = 1'b1;
    int     m_d;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lvl = 0;
            m_dir = 0;
            m_ack = 1'b1;
            m_cyc = 0;
            m_next = 0;
        end else begin
            m_d = (step_cycles == 0) ? 1 : int'(step_cycles);
            m_cyc++;
            if (m_dir == 0) begin
                if (m_ack && !sleep_req) begin
                    m_lvl = 1; m_dir = 1; m_next = m_cyc + m_d;
                end else if (!m_ack && sleep_req) begin
                    m_lvl = N - 1; m_dir = -1; m_next = m_cyc + m_d;
                end
            end else if (m_dir == 1 && sleep_req) begin
                m_lvl--; m_dir = -1; m_next = m_cyc + m_d;
            end else if (m_dir == -1 && !sleep_req) begin
                m_lvl++; m_dir = 1; m_next = m_cyc + m_d;
            end else if (m_cyc == m_next) begin
                if (m_dir == 1) begin
                    if (m_lvl < N) begin
                        m_lvl++; m_next = m_cyc + m_d;
                    end else begin
                        m_dir = 0; m_ack = 1'b0;
                    end
                end else begin
                    if (m_lvl > 0) begin
                        m_lvl--; m_next = m_cyc + m_d;
                    end else begin
                        m_dir = 0; m_ack = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Reset pulses may clear several bits at once; skip the one-step rule across them.
    bit rst_hit = 1'b1;
    always @(negedge rst) rst_hit = 1'b1;

    logic [N-1:0] prev_en = '0;
    logic [N-1:0] exp_en;
    logic [N-1:0] inc_en;

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) exp_en[i] = (i < m_lvl);
        chk("switch_en", 32'(switch_en), 32'(exp_en));
        chk("sleep_ack", 32'(sleep_ack), 32'(m_ack));
        chk("busy",      32'(busy),      32'(m_dir != 0));
        inc_en = switch_en + 1'b1;
        n_checks++;
        assert (((switch_en & inc_en) == '0) &&
                (rst_hit || $countones(switch_en ^ prev_en) <= 1))
            n_pass++;
        else
            $display("FAIL therm_step: got %h prev %h at %0t", switch_en, prev_en, $time);
        prev_en = switch_en;
        rst_hit = 1'b0;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int hold;

    initial begin
        rst = 1'b1;
        sleep_req = 1'b1;
        step_cycles = 8'd4;
        #1 rst = 1'b0;
        tick(2);
        #1 rst = 1'b1;
        tick(2);
        chk("reset_en",   32'(switch_en), 32'h00);
        chk("reset_ack",  32'(sleep_ack), 32'h1);
        chk("reset_busy", 32'(busy),      32'h0);

        // Power-up, D=4
        sleep_req = 1'b0;
        tick(1);  chk("up_k_en", 32'(switch_en), 32'h01);
                  chk("up_k_busy", 32'(busy), 32'h1);
        tick(27); chk("up_k27_en", 32'(switch_en), 32'h7F);
        tick(1);  chk("up_k28_en", 32'(switch_en), 32'hFF);
        tick(3);  chk("up_k31_busy", 32'(busy), 32'h1);
                  chk("up_k31_ack", 32'(sleep_ack), 32'h1);
        tick(1);  chk("up_k32_ack", 32'(sleep_ack), 32'h0);
                  chk("up_k32_busy", 32'(busy), 32'h0);
        tick(3);

        // Power-down, D=2
        step_cycles = 8'd2;
        sleep_req = 1'b1;
        tick(1);  chk("dn_k_en", 32'(switch_en), 32'h7F);
                  chk("dn_k_ack", 32'(sleep_ack), 32'h0);
        tick(14); chk("dn_k14_en", 32'(switch_en), 32'h00);
        tick(1);  chk("dn_k15_ack", 32'(sleep_ack), 32'h0);
                  chk("dn_k15_busy", 32'(busy), 32'h1);
        tick(1);  chk("dn_k16_ack", 32'(sleep_ack), 32'h1);
                  chk("dn_k16_busy", 32'(busy), 32'h0);
        tick(2);

        // Reversal, D=3
        step_cycles = 8'd3;
        sleep_req = 1'b0;
        tick(1);  chk("rev_k_en", 32'(switch_en), 32'h01);
        tick(6);  chk("rev_k6_en", 32'(switch_en), 32'h07);
        sleep_req = 1'b1;
        tick(1);  chk("rev_k7_en", 32'(switch_en), 32'h03);
                  chk("rev_k7_ack", 32'(sleep_ack), 32'h1);
        tick(3);  chk("rev_k10_en", 32'(switch_en), 32'h01);
        tick(3);  chk("rev_k13_en", 32'(switch_en), 32'h00);
                  chk("rev_k13_busy", 32'(busy), 32'h1);
        tick(3);  chk("rev_k16_busy", 32'(busy), 32'h0);
                  chk("rev_k16_ack", 32'(sleep_ack), 32'h1);
        tick(2);

        // step_cycles = 0 acts as D=1
        step_cycles = 8'd0;
        sleep_req = 1'b0;
        tick(1);  chk("z_k_en", 32'(switch_en), 32'h01);
        tick(7);  chk("z_k7_en", 32'(switch_en), 32'hFF);
                  chk("z_k7_ack", 32'(sleep_ack), 32'h1);
        tick(1);  chk("z_k8_ack", 32'(sleep_ack), 32'h0);
        sleep_req = 1'b1;
        tick(10); chk("z_off_ack", 32'(sleep_ack), 32'h1);

        // Reset in the middle of a ramp
        step_cycles = 8'd2;
        sleep_req = 1'b0;
        tick(1);
        tick(8);  chk("rr_pre_en", 32'(switch_en), 32'h1F);
        #2 rst = 1'b0;
        #1;
        chk("rr_en",   32'(switch_en), 32'h00);
        chk("rr_ack",  32'(sleep_ack), 32'h1);
        chk("rr_busy", 32'(busy),      32'h0);
        @(negedge clk);
        #1 rst = 1'b1;
        tick(1);  chk("rr_restart_en", 32'(switch_en), 32'h01);

        // Randomized phase
        hold = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            #1;
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) rst = 1'b0;
            if (hold == 0) begin
                sleep_req   = 1'($urandom_range(0, 1));
                hold        = $urandom_range(1, 45);
                step_cycles = 8'($urandom_range(0, 5));
            end else begin
                hold--;
                if ($urandom_range(0, 15) == 0) step_cycles = 8'($urandom_range(0, 5));
            end
        end
        rst = 1'b1;
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/power_switch_ctrl.md
POWER_SWITCH_CTRL -- requirements
Module: power_switch_ctrl

Interface
REQ-001 SHALL have parameter N_SWITCH, default 8, number of power-switch segments in the daisy chain (N_SWITCH >= 1).
REQ-002 SHALL have parameter STEP_W, default 8, width of the inter-segment delay configuration.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port sleep_req  input  1  request from the power-gate FSM: 1 = domain off, 0 = domain on.
REQ-006 SHALL have port step_cycles  input  STEP_W  cycles between consecutive segment toggles; 0 treated as 1.
REQ-007 SHALL have port switch_en  output  N_SWITCH  registered per-segment switch enables; bit i = 1 means segment i conducts.
REQ-008 SHALL have port sleep_ack  output  1  registered acknowledge: 1 = all segments off, 0 = all segments on.
REQ-009 SHALL have port busy  output  1  registered; 1 while a ramp is in progress.

Function
REQ-010 SHALL implement states OFF, RAMP_UP, ON, RAMP_DOWN, plus a segment index idx (0..N_SWITCH) and a delay timer; D = max(step_cycles,1), sampled at every timer reload.
REQ-011 SHALL, in OFF with sleep_req=0 sampled at edge k: enter RAMP_UP, set switch_en[0], idx=1, timer=D-1, busy=1.
REQ-012 SHALL, in RAMP_UP, per edge: timer>0 -> decrement; timer=0 and idx<N_SWITCH -> set switch_en[idx], idx+1, timer=D-1; timer=0 and idx=N_SWITCH -> enter ON, sleep_ack=0, busy=0.
REQ-013 SHALL produce power-up timing: switch_en[i] rises at edge k+i*D; sleep_ack falls at edge k+N_SWITCH*D.
REQ-014 SHALL, in ON with sleep_req=1 sampled at edge k: enter RAMP_DOWN, clear switch_en[N_SWITCH-1], idx=N_SWITCH-1, timer=D-1, busy=1.
REQ-015 SHALL, in RAMP_DOWN, mirror REQ-012 in reverse order: clear switch_en[idx-1], idx-1; when idx=0 and timer=0 enter OFF, sleep_ack=1, busy=0.
REQ-016 SHALL produce power-down timing: switch_en[N_SWITCH-1-i] falls at edge k+i*D; sleep_ack rises at edge k+N_SWITCH*D.
REQ-017 SHALL change sleep_ack only on entry to ON (to 0) or OFF (to 1); it SHALL hold its value throughout any ramp.
REQ-018 SHALL, on sleep_req=1 sampled in RAMP_UP: enter RAMP_DOWN at that edge, clear switch_en[idx-1], idx-1, timer=D-1 (immediate reversal, no wait for timer).
REQ-019 SHALL, on sleep_req=0 sampled in RAMP_DOWN: enter RAMP_UP at that edge, set switch_en[idx], idx+1, timer=D-1.
REQ-020 SHALL keep switch_en thermometer-coded at all times (bits 0..idx-1 set, others clear); never more than one bit toggles per edge.
REQ-021 SHALL ignore sleep_req=1 in OFF and sleep_req=0 in ON (no output change).
REQ-022 SHALL treat step_cycles changes mid-ramp as effective only at the next timer reload.
REQ-023 SHALL, with N_SWITCH=1, still apply the full D-cycle settle before sleep_ack changes.

Reset
REQ-024 SHALL, while rst=0, asynchronously force state=OFF, switch_en=0, sleep_ack=1, busy=0, idx=0, timer=0, regardless of any ramp in progress.
REQ-025 SHALL, after rst deasserts, begin a power-up ramp only on the first edge sampling sleep_req=0.

Verification
REQ-026 SHALL verify power-up: N_SWITCH=8, step_cycles=4, sleep_req 1->0 sampled at edge k -> switch_en bits rise at k, k+4, ..., k+28; sleep_ack falls at k+32; busy high k..k+31.
REQ-027 SHALL verify power-down: from ON, step_cycles=2, sleep_req 0->1 at edge k -> switch_en[7..0] fall at k, k+2, ..., k+14; sleep_ack rises at k+16.
REQ-028 SHALL verify reversal: step_cycles=3, power-up started at edge k, sleep_req=1 at edge k+7 (switch_en=8'h07) -> switch_en=8'h03 at k+7, 8'h01 at k+10, 8'h00 at k+13, sleep_ack stays 1 throughout.
REQ-029 SHALL verify step_cycles=0: behaves as D=1; full power-up completes with sleep_ack=0 at k+8.
REQ-030 SHALL verify reset mid-ramp: rst=0 while switch_en=8'h1F -> switch_en=0, sleep_ack=1, busy=0 immediately, without a clock edge.
REQ-031 SHALL verify with an assertion that switch_en is always thermometer-coded and changes by at most one bit per edge.
